// File: rtl/block_sync_slip_ctrl.sv
// block_sync_slip_ctrl: round-robin bit-slip scheduler sharing one gearbox slip port across PCS lanes
// ports: clk, reset (async, active high); slip_req_i / lock_i per-lane inputs;
//        gb_slip_v_o / gb_slip_lane_o gearbox slip command; slip_done_o per-lane settle pulse;
//        rx_mask_o lanes with a slip pending or in flight; busy_o FSM active; all_lock_o registered lock summary
module block_sync_slip_ctrl #(
    parameter int LANE_N    = 4,
    parameter int LANE_W    = $clog2(LANE_N),
    parameter int SLIP_WAIT = 4,
    parameter int CNT_W     = $clog2(SLIP_WAIT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LANE_N-1:0] slip_req_i,
    input  logic [LANE_N-1:0] lock_i,
    output logic              gb_slip_v_o,
    output logic [LANE_W-1:0] gb_slip_lane_o,
    output logic [LANE_N-1:0] slip_done_o,
    output logic [LANE_N-1:0] rx_mask_o,
    output logic              busy_o,
    output logic              all_lock_o
);
    localparam logic [3:0] IDLE = 4'b0001;
    localparam logic [3:0] SLIP = 4'b0010;
    localparam logic [3:0] WAIT = 4'b0100;
    localparam logic [3:0] DONE = 4'b1000;
    logic [3:0]        state_q, state_d;
    logic [LANE_N-1:0] pend_q;
    logic [LANE_W-1:0] lane_q, ptr_q, gnt;
    logic [CNT_W-1:0]  cnt_q;
    logic              all_lock_q;
    // lowest pending lane overall covers the wrap case; lowest pending lane above ptr_q overrides it
    always_comb begin
        gnt = '0;
        for (int j = LANE_N - 1; j >= 0; j--)
            if (pend_q[j]) gnt = LANE_W'(j);
        for (int j = LANE_N - 1; j >= 0; j--)
            if (pend_q[j] && j > int'(ptr_q)) gnt = LANE_W'(j);
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = |pend_q ? SLIP : IDLE;
            SLIP:    state_d = WAIT;
            WAIT:    state_d = cnt_q == '0 ? DONE : WAIT;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        gb_slip_v_o    = state_q == SLIP;
        gb_slip_lane_o = lane_q;
        busy_o         = state_q != IDLE;
        rx_mask_o      = pend_q;
        all_lock_o     = all_lock_q;
        slip_done_o    = '0;
        if (state_q == DONE) slip_done_o[lane_q] = 1'b1;
    end
    // a request landing in the lane's own DONE cycle survives the clear, so the lane is slipped again
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pend_q     <= '0;
            lane_q     <= '0;
            ptr_q      <= LANE_W'(LANE_N - 1);
            cnt_q      <= '0;
            all_lock_q <= 1'b0;
        end else begin
            pend_q     <= (pend_q & ~slip_done_o) | slip_req_i;
            all_lock_q <= &lock_i & ~|pend_q;
            if (state_q == IDLE && |pend_q) begin
                lane_q <= gnt;
                ptr_q  <= gnt;
            end
            cnt_q <= state_q == SLIP ? CNT_W'(SLIP_WAIT - 1)
                   : (state_q == WAIT && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        end
endmodule

// File: tb/tb_block_sync_slip_ctrl.sv
// tb_block_sync_slip_ctrl: scoreboard bench for the shared slip scheduler
module tb_block_sync_slip_ctrl;
    localparam int N  = 4;
    localparam int SW = 4;
    localparam int P  = SW + 3;
    typedef struct {int lane; int cyc;} ev_t;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] slip_req_i = '0;
    logic [N-1:0] lock_i = '0;
    logic         gb_slip_v_o;
    logic [1:0]   gb_slip_lane_o;
    logic [N-1:0] slip_done_o;
    logic [N-1:0] rx_mask_o;
    logic         busy_o;
    logic         all_lock_o;
    ev_t          exp_slip[$];
    ev_t          exp_done[$];
    ev_t          mon_e;
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    int           t, u;

    block_sync_slip_ctrl #(.LANE_N(N), .SLIP_WAIT(SW)) dut (
        .clk(clk), .reset(reset), .slip_req_i(slip_req_i), .lock_i(lock_i),
        .gb_slip_v_o(gb_slip_v_o), .gb_slip_lane_o(gb_slip_lane_o), .slip_done_o(slip_done_o),
        .rx_mask_o(rx_mask_o), .busy_o(busy_o), .all_lock_o(all_lock_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h with nothing expected at cycle %0d", name, act, cyc);
    endtask

    // a slip at cycle c implies its done pulse SW+1 cycles later
    task automatic expect_slip(input int lane, input int c, input bit with_done);
        exp_slip.push_back('{lane, c});
        if (with_done) exp_done.push_back('{lane, c + SW + 1});
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic req(input logic [N-1:0] m);
        slip_req_i = m;
        @(negedge clk);
        slip_req_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic end_check(input string name);
        chk({name, "_slips_left"}, exp_slip.size(), 0);
        chk({name, "_dones_left"}, exp_done.size(), 0);
        exp_slip.delete();
        exp_done.delete();
    endtask

    always @(negedge clk)
        if (!reset) begin
            if (gb_slip_v_o) begin
                if (exp_slip.size() == 0) unexpected("slip_unexpected", 32'(gb_slip_lane_o));
                else begin
                    mon_e = exp_slip.pop_front();
                    chk("slip_lane", 32'(gb_slip_lane_o), mon_e.lane);
                    chk("slip_cycle", cyc, mon_e.cyc);
                end
            end
            if (slip_done_o != '0) begin
                if (exp_done.size() == 0) unexpected("done_unexpected", 32'(slip_done_o));
                else begin
                    mon_e = exp_done.pop_front();
                    chk("done_vec", 32'(slip_done_o), 32'(1) << mon_e.lane);
                    chk("done_cycle", cyc, mon_e.cyc);
                end
            end
        end

    initial begin
        wait_to(3);
        reset = 1'b0;
        chk("rst_slip_v", 32'(gb_slip_v_o), 0);
        chk("rst_slip_lane", 32'(gb_slip_lane_o), 0);
        chk("rst_done", 32'(slip_done_o), 0);
        chk("rst_mask", 32'(rx_mask_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_all_lock", 32'(all_lock_o), 0);
        // single request on lane 2
        t = cyc + 2;
        wait_to(t);
        expect_slip(2, t + 2, 1);
        req(4'b0100);
        chk("t1_mask_set", 32'(rx_mask_o), 32'h4);
        wait_to(t + 2);
        chk("t1_busy", 32'(busy_o), 1);
        wait_to(t + 3 + SW);
        chk("t1_mask_done", 32'(rx_mask_o), 32'h4);
        wait_to(t + 4 + SW);
        chk("t1_mask_clr", 32'(rx_mask_o), 0);
        chk("t1_idle", 32'(busy_o), 0);
        end_check("t1");
        // lanes 0,1,3 together: served 0,1,3 one period apart
        do_reset();
        t = cyc;
        expect_slip(0, t + 2, 1);
        expect_slip(1, t + 2 + P, 1);
        expect_slip(3, t + 2 + 2 * P, 1);
        req(4'b1011);
        wait_to(t + 2 + 2 * P + SW + 3);
        chk("t2_mask_clr", 32'(rx_mask_o), 0);
        end_check("t2");
        // fairness: each lane re-requests in its own DONE while the other is pending
        do_reset();
        t = cyc;
        expect_slip(0, t + 2, 1);
        expect_slip(1, t + 2 + P, 1);
        expect_slip(0, t + 2 + 2 * P, 1);
        expect_slip(1, t + 2 + 3 * P, 1);
        req(4'b0011);
        wait_to(t + 7);
        req(4'b0001);
        wait_to(t + 14);
        req(4'b0010);
        wait_to(t + 2 + 3 * P + SW + 3);
        chk("t3_mask_clr", 32'(rx_mask_o), 0);
        end_check("t3");
        // lane 2 re-requests during its own DONE: mask never drops, second slip one period later
        do_reset();
        t = cyc;
        expect_slip(2, t + 2, 1);
        expect_slip(2, t + 2 + P, 1);
        slip_req_i = 4'b0100;
        for (int c = t + 1; c <= t + 14; c++) begin
            wait_to(c);
            slip_req_i = (c == t + 7) ? 4'b0100 : 4'b0000;
            chk("t4_mask2_held", 32'(rx_mask_o[2]), 1);
        end
        slip_req_i = '0;
        wait_to(t + 15);
        chk("t4_mask_clr", 32'(rx_mask_o), 0);
        end_check("t4");
        // lane 1 hammers requests through WAIT: only one slip results
        do_reset();
        t = cyc;
        expect_slip(1, t + 2, 1);
        req(4'b0010);
        for (int c = t + 3; c <= t + 6; c++) begin
            wait_to(c);
            slip_req_i = 4'b0010;
        end
        wait_to(t + 7);
        slip_req_i = '0;
        wait_to(t + 16);
        chk("t5_mask_clr", 32'(rx_mask_o), 0);
        chk("t5_idle", 32'(busy_o), 0);
        end_check("t5");
        // lock aggregation, then reset in the middle of WAIT
        do_reset();
        t = cyc;
        lock_i = 4'b1111;
        chk("t6_lock_lag", 32'(all_lock_o), 0);
        wait_to(t + 1);
        chk("t6_lock_set", 32'(all_lock_o), 1);
        u = cyc;
        expect_slip(3, u + 2, 0);
        req(4'b1000);
        wait_to(u + 2);
        chk("t6_lock_drop", 32'(all_lock_o), 0);
        wait_to(u + 4);
        chk("t6_busy_pre", 32'(busy_o), 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy_o), 0);
        chk("t6_rst_mask", 32'(rx_mask_o), 0);
        chk("t6_rst_lock", 32'(all_lock_o), 0);
        wait_to(u + 6);
        reset = 1'b0;
        wait_to(u + 14);
        chk("t6_idle_after", 32'(busy_o), 0);
        end_check("t6");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
